knight_rider_ctrl: RTL and testbench

Sequencer for the 8-LED Knight Rider bar on the Red Pitaya board. A programmable prescaler generates step ticks from the fabric clock. A small FSM walks a position register in one of three scan modes and drives a registered LED pattern. An optional mirror path, the existing reverse_bits datapath, flips the pattern before the output register. The block sits between the config/GPIO registers and the LED pins.

---
 rtl/knight_rider_ctrl_pkg.sv | 29 ++
 rtl/knight_rider_ctrl_reverse_bits.sv | 12 +
 rtl/knight_rider_ctrl.sv | 138 +++++++++++++
 tb/tb_knight_rider_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/knight_rider_ctrl_pkg.sv
// Shared encodings for the Knight Rider LED sequencer: scan modes, scan direction, FSM states.
package knight_rider_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_WRAP   = 2'd1,
        MODE_TAIL   = 2'd2
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // The unused encoding 3 behaves as plain bounce.
    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_BOUNCE : mode_e'(m);
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] p);
        return 8'd1 << p;
    endfunction

endpackage

// File: rtl/knight_rider_ctrl_reverse_bits.sv
// Mirror stage: purely combinational 8-bit reversal, bit i takes bit 7-i.
// Zero latency, no flow control.
module knight_rider_ctrl_reverse_bits (
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat
);

    for (genvar g = 0; g < 8; g++) begin : g_rev
        assign o_dat[g] = i_dat[7-g];
    end

endmodule

// File: rtl/knight_rider_ctrl.sv
// Knight Rider bar sequencer: prescaled step ticks walk a position in bounce/wrap/tail modes.
// led_o trails a position update by one cycle; tick_o/end_o align with the new led_o value; no backpressure.
module knight_rider_ctrl
    import knight_rider_ctrl_pkg::*;
#(
    parameter int LED_W = 8,
    parameter int PRE_W = 27
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             en_i,
    input  logic [PRE_W-1:0] period_i,
    input  logic [1:0]       mode_i,
    input  logic             mirror_i,
    output logic [LED_W-1:0] led_o,
    output logic             tick_o,
    output logic             end_o
);

    state_e           r_state;
    logic [PRE_W-1:0] r_cnt;
    logic [2:0]       r_pos;
    logic [2:0]       r_prev;
    dir_e             r_dir;
    mode_e            r_mode;
    logic             r_step_q;
    logic             r_end_q;

    state_e           w_state_nxt;
    logic             w_step;
    logic             w_end;
    logic [2:0]       w_pos_nxt;
    dir_e             w_dir_nxt;
    mode_e            w_mode_nxt;
    logic             w_show;
    logic [7:0]       w_pattern;
    logic [7:0]       w_pattern_rev;
    logic [LED_W-1:0] w_pattern_m;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        w_end       = 1'b0;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_mode_nxt  = norm_mode(mode_i);

        case (r_state)
            IDLE: begin
                if (en_i) w_state_nxt = RUN;
            end
            RUN: begin
                // >= so that lowering period_i below the running count steps at once
                w_step = (r_cnt >= period_i);
                if (!en_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_mode_nxt == MODE_WRAP) begin
            w_pos_nxt = r_pos + 3'd1;
            w_dir_nxt = DIR_LEFT;
            w_end     = (r_pos == 3'd7);
        end else if (r_dir == DIR_LEFT) begin
            if (r_pos == 3'd7) begin
                w_pos_nxt = 3'd6;
                w_dir_nxt = DIR_RIGHT;
                w_end     = 1'b1;
            end else begin
                w_pos_nxt = r_pos + 3'd1;
            end
        end else begin
            if (r_pos == 3'd0) begin
                w_pos_nxt = 3'd1;
                w_dir_nxt = DIR_LEFT;
                w_end     = 1'b1;
            end else begin
                w_pos_nxt = r_pos - 3'd1;
            end
        end
    end

    // The pattern follows the mode latched at the last step, mirror follows the live input.
    assign w_pattern = onehot8(r_pos) | ((r_mode == MODE_TAIL) ? onehot8(r_prev) : 8'h00);

    knight_rider_ctrl_reverse_bits u_mirror (
        .i_dat (w_pattern),
        .o_dat (w_pattern_rev)
    );

    assign w_pattern_m = mirror_i ? w_pattern_rev : w_pattern;
    assign w_show      = (r_state == RUN) || en_i;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt    <= '0;
            r_pos    <= 3'd0;
            r_prev   <= 3'd0;
            r_dir    <= DIR_LEFT;
            r_mode   <= MODE_BOUNCE;
            r_step_q <= 1'b0;
            r_end_q  <= 1'b0;
            led_o    <= '0;
            tick_o   <= 1'b0;
            end_o    <= 1'b0;
        end else begin
            if (r_state == RUN) begin
                r_cnt <= w_step ? '0 : r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (w_step) begin
                r_pos  <= w_pos_nxt;
                r_prev <= r_pos;
                r_dir  <= w_dir_nxt;
                r_mode <= w_mode_nxt;
            end

            r_step_q <= w_step;
            r_end_q  <= w_step & w_end;

            // Pulses are suppressed when the bar is blanked so a tick never marks a dark bar.
            led_o  <= w_show ? w_pattern_m : '0;
            tick_o <= w_show & r_step_q;
            end_o  <= w_show & r_end_q;
        end
    end

endmodule

// File: tb/tb_knight_rider_ctrl.sv
// Bench for knight_rider_ctrl: reference model predicts each cycle's outputs into a queue,
// a negedge monitor pops and compares against the DUT.
module tb_knight_rider_ctrl;

    localparam int PRE_W = 27;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic             en_i;
    logic [PRE_W-1:0] period_i;
    logic [1:0]       mode_i;
    logic             mirror_i;
    logic [7:0]       led_o;
    logic             tick_o;
    logic             end_o;

    knight_rider_ctrl #(.LED_W(8), .PRE_W(PRE_W)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .en_i     (en_i),
        .period_i (period_i),
        .mode_i   (mode_i),
        .mirror_i (mirror_i),
        .led_o    (led_o),
        .tick_o   (tick_o),
        .end_o    (end_o)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [7:0] led;
        logic       tick;
        logic       endf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_ticks  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: position reflects off the bar ends, or wraps modulo 8.
    int  m_pos, m_prev, m_dir, m_mode, m_cnt;
    bit  m_run, m_pend_tick, m_pend_end;

    function automatic logic [7:0] model_led(input int pos, input int prev, input bit tail,
                                             input bit mir);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == pos || (tail && i == prev)) v[mir ? 7 - i : i] = 1'b1;
        end
        return v;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_pos = 0; m_prev = 0; m_dir = 1; m_mode = 0; m_cnt = 0;
            m_run = 0; m_pend_tick = 0; m_pend_end = 0;
            m_dir = 0;
            exp_q.delete();
            exp_q.push_back('{led: 8'h00, tick: 1'b0, endf: 1'b0});
        end else begin
            exp_t e;
            bit   show, step;
            int   delta, np;
            show   = m_run || en_i;
            e.led  = show ? model_led(m_pos, m_prev, m_mode == 2, mirror_i) : 8'h00;
            e.tick = show && m_pend_tick;
            e.endf = show && m_pend_end;
            step = m_run && (m_cnt >= int'(period_i));
            m_pend_tick = step;
            m_pend_end  = 1'b0;
            if (step) begin
                m_prev = m_pos;
                m_mode = (mode_i == 2'd3) ? 0 : int'(mode_i);
                if (m_mode == 1) begin
                    np = (m_pos + 1) % 8;
                    m_pend_end = (np == 0);
                    m_dir = 0;
                end else begin
                    delta = (m_dir == 1) ? -1 : 1;
                    np = m_pos + delta;
                    if (np < 0 || np > 7) begin
                        np = m_pos - delta;
                        m_dir = 1 - m_dir;
                        m_pend_end = 1'b1;
                    end
                end
                m_pos = np;
            end
            m_cnt = (m_run && !step) ? m_cnt + 1 : 0;
            m_run = en_i;
            exp_q.push_back(e);
        end
    end

    always @(negedge aclk) begin
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
        end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("led_o", 32'(led_o), 32'(e.led));
            check("tick_o", 32'(tick_o), 32'(e.tick));
            check("end_o", 32'(end_o), 32'(e.endf));
            if (tick_o === 1'b1) n_ticks++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Assert reset between edges, check the outputs clear without a clock, release mid-cycle.
    task automatic async_reset();
        #1 aresetn = 1'b0;
        #1;
        check("rst_led_async", 32'(led_o), 32'h0);
        check("rst_tick_async", 32'(tick_o), 32'h0);
        check("rst_end_async", 32'(end_o), 32'h0);
        @(negedge aclk);
        @(negedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn  = 1'b0;
        en_i     = 1'b0;
        period_i = PRE_W'(3);
        mode_i   = 2'd0;
        mirror_i = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_led", 32'(led_o), 32'h0);
        check("rst_tick", 32'(tick_o), 32'h0);
        @(negedge aclk);
        #2 aresetn = 1'b1;
        cyc(1);

        en_i = 1'b1;
        cyc(70);

        mode_i = 2'd1; period_i = '0;
        cyc(20);

        mode_i = 2'd2; period_i = PRE_W'(1);
        cyc(40);

        mode_i = 2'd0; period_i = PRE_W'(2); mirror_i = 1'b1;
        cyc(25);
        mirror_i = 1'b0;
        cyc(3);
        mirror_i = 1'b1;
        cyc(10);

        en_i = 1'b0;
        cyc(12);
        en_i = 1'b1;
        cyc(30);

        period_i = PRE_W'(3); mode_i = 2'd3;
        cyc(9);
        async_reset();
        cyc(25);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 49) == 0) en_i = ~en_i;
            if ($urandom_range(0, 19) == 0) period_i = PRE_W'($urandom_range(0, 5));
            if ($urandom_range(0, 29) == 0) mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) mirror_i = ~mirror_i;
            if ($urandom_range(0, 299) == 0) async_reset();
            else cyc(1);
        end

        @(negedge aclk);
        #1;
        if (n_ticks == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_seen actual=0 required=nonzero");
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
